ula_adder_bios: RTL and testbench



---
 rtl/ula_adder_bios_if.sv | 23 ++
 rtl/ula_adder_bios.sv | 91 +++++++++
 tb/tb_ula_adder_bios.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ula_adder_bios_if.sv
// Bus bundle for ula_adder_bios: ULA operands/results, PC incrementer and BIOS boot stream.
interface ula_adder_bios_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  opcode;
    logic [31:0] Out;
    logic        zero;
    logic [3:0]  flags;
    logic [31:0] dataA;
    logic [31:0] result;
    logic [31:0] captured_data;
    logic        bios_done;

    modport master (
        output A, B, opcode, dataA,
        input  Out, zero, flags, result, captured_data, bios_done
    );

    modport slave (
        input  A, B, opcode, dataA,
        output Out, zero, flags, result, captured_data, bios_done
    );
endinterface

// File: rtl/ula_adder_bios.sv
// Combinational ULA with registered NZCV flags, PC+1 adder, and a BIOS boot-word
// emitter that streams BIOS_DEPTH words after reset release and then parks at zero.
module ula_adder_bios #(
    parameter int          BIOS_DEPTH = 6,
    parameter logic [31:0] BIOS_BASE  = 32'hB105_0000
) (
    input  logic           clock,
    input  logic           reset,
    ula_adder_bios_if.slave bus
);
    localparam logic [8:0] LAST_IDX = 9'(BIOS_DEPTH - 1);

    logic [31:0] arith_b, b_eff, alu_out;
    logic [32:0] sum;
    logic        arith_op, arith_sub, c_flag, v_flag, alu_zero;
    logic [3:0]  flags_q;
    logic [8:0]  idx;
    logic [31:0] captured_q;
    logic        done_q;

    // ADD/SUB/INC/DEC share one adder; subtraction is A + ~B + 1 so the
    // carry out is the borrow complement (A >= B unsigned).
    always_comb begin
        arith_op  = 1'b0;
        arith_sub = 1'b0;
        arith_b   = bus.B;
        case (bus.opcode)
            5'd0:  arith_op = 1'b1;
            5'd1:  begin arith_op = 1'b1; arith_sub = 1'b1; end
            5'd12: begin arith_op = 1'b1; arith_b = 32'd1; end
            5'd13: begin arith_op = 1'b1; arith_sub = 1'b1; arith_b = 32'd1; end
            default: ;
        endcase
    end

    assign b_eff  = arith_sub ? ~arith_b : arith_b;
    assign sum    = {1'b0, bus.A} + {1'b0, b_eff} + {32'b0, arith_sub};
    assign c_flag = arith_op & sum[32];
    assign v_flag = arith_op & (bus.A[31] == b_eff[31]) & (sum[31] != bus.A[31]);

    always_comb begin
        alu_out = 32'd0;
        case (bus.opcode)
            5'd0, 5'd1, 5'd12, 5'd13: alu_out = sum[31:0];
            5'd2:  alu_out = bus.A & bus.B;
            5'd3:  alu_out = bus.A | bus.B;
            5'd4:  alu_out = bus.A ^ bus.B;
            5'd5:  alu_out = ~bus.A;
            5'd6:  alu_out = bus.A << bus.B[4:0];
            5'd7:  alu_out = bus.A >> bus.B[4:0];
            5'd8:  alu_out = $signed(bus.A) >>> bus.B[4:0];
            5'd9:  alu_out = {31'd0, $signed(bus.A) < $signed(bus.B)};
            5'd10: alu_out = {31'd0, bus.A < bus.B};
            5'd11: alu_out = bus.B;
            5'd14: alu_out = ~(bus.A & bus.B);
            5'd15: alu_out = ~(bus.A | bus.B);
            default: alu_out = 32'd0;
        endcase
    end

    assign alu_zero   = (alu_out == 32'd0);
    assign bus.Out    = alu_out;
    assign bus.zero   = alu_zero;
    assign bus.result = bus.dataA + 32'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) flags_q <= 4'b0000;
        else        flags_q <= {alu_out[31], alu_zero, c_flag, v_flag};
    end

    // Index stops at the last word; only reset can restart the stream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx        <= 9'd0;
            captured_q <= BIOS_BASE;
            done_q     <= 1'b0;
        end else if (!done_q) begin
            if (idx == LAST_IDX) begin
                done_q     <= 1'b1;
                captured_q <= 32'd0;
            end else begin
                idx        <= idx + 9'd1;
                captured_q <= BIOS_BASE | {23'd0, idx + 9'd1};
            end
        end
    end

    assign bus.flags         = flags_q;
    assign bus.captured_data = captured_q;
    assign bus.bios_done     = done_q;
endmodule

// File: tb/tb_ula_adder_bios.sv
// Self-checking bench for ula_adder_bios: ULA directed/random vectors, PC adder,
// BIOS boot stream and mid-sequence reset abort, using expectation queues.
module tb_ula_adder_bios;
    localparam logic [31:0] BASE  = 32'hB105_0000;
    localparam int          DEPTH = 6;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ula_adder_bios_if bus();

    ula_adder_bios #(.BIOS_DEPTH(DEPTH), .BIOS_BASE(BASE)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [31:0] out;
        logic        zero;
        logic [3:0]  flags;
    } ula_exp_t;

    ula_exp_t    ula_q[$];
    logic [32:0] bios_q[$];

    // Reference ULA: wide unsigned arithmetic for carry, 64-bit signed for overflow.
    function automatic void model_ula(input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] op,
                                      output logic [31:0] o, output logic [3:0] f);
        logic [32:0] w;
        int          sa_i, sb_i;
        longint      sa, sb, sr;
        logic        c, v;
        sa_i = a; sb_i = b; sa = sa_i; sb = sb_i;
        c = 1'b0; v = 1'b0; sr = 0;
        case (op)
            5'd0:  begin w = {1'b0, a} + {1'b0, b}; o = w[31:0]; c = w[32]; sr = sa + sb; v = sr[32] != sr[31]; end
            5'd1:  begin o = a - b; c = (a >= b); sr = sa - sb; v = sr[32] != sr[31]; end
            5'd12: begin o = a + 32'd1; c = (a == 32'hFFFF_FFFF); sr = sa + 1; v = sr[32] != sr[31]; end
            5'd13: begin o = a - 32'd1; c = (a != 32'd0); sr = sa - 1; v = sr[32] != sr[31]; end
            5'd2:  o = a & b;
            5'd3:  o = a | b;
            5'd4:  o = a ^ b;
            5'd5:  o = ~a;
            5'd6:  o = a << b[4:0];
            5'd7:  o = a >> b[4:0];
            5'd8:  begin sr = sa >>> b[4:0]; o = sr[31:0]; end
            5'd9:  o = (sa < sb) ? 32'd1 : 32'd0;
            5'd10: o = (a < b) ? 32'd1 : 32'd0;
            5'd11: o = b;
            5'd14: o = ~(a & b);
            5'd15: o = ~(a | b);
            default: o = 32'd0;
        endcase
        f = {o[31], o == 32'd0, c, v};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.A = 32'd9; bus.B = 32'd4; bus.opcode = 5'd1; bus.dataA = 32'd41;
        #1 reset = 1'b0;
        #1;
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %h want 0", bus.flags); end
        checks++; if (bus.captured_data !== BASE) begin errors++; $display("FAIL reset_word got %h want %h", bus.captured_data, BASE); end
        checks++; if (bus.bios_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.bios_done); end
        checks++; if (bus.Out !== 32'd5) begin errors++; $display("FAIL reset_comb_out got %h want 5", bus.Out); end
        checks++; if (bus.result !== 32'd42) begin errors++; $display("FAIL reset_comb_result got %h want 42", bus.result); end
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.captured_data !== BASE || bus.bios_done !== 1'b0 || bus.flags !== 4'b0) begin
            errors++; $display("FAIL reset_hold got %h/%b/%h want %h/0/0", bus.captured_data, bus.bios_done, bus.flags, BASE);
        end
    endtask

    task automatic test_bios_sequence();
        logic [32:0] e;
        for (int i = 0; i < DEPTH; i++) bios_q.push_back({1'b0, BASE | 32'(i)});
        for (int i = 0; i < 12; i++) bios_q.push_back({1'b1, 32'd0});
        @(negedge clock) reset = 1'b1;
        #1;
        while (bios_q.size() > 0) begin
            e = bios_q.pop_front();
            checks++;
            if ({bus.bios_done, bus.captured_data} !== e) begin
                errors++; $display("FAIL bios_seq got %b/%h want %b/%h", bus.bios_done, bus.captured_data, e[32], e[31:0]);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic drive_ula_item(input ula_exp_t it);
        ula_exp_t x;
        @(negedge clock);
        bus.A = it.a; bus.B = it.b; bus.opcode = it.op;
        ula_q.push_back(it);
        #1;
        checks++;
        if (bus.Out !== ula_q[0].out || bus.zero !== ula_q[0].zero) begin
            errors++; $display("FAIL ula_out op=%0d a=%h b=%h got %h/%b want %h/%b",
                               it.op, it.a, it.b, bus.Out, bus.zero, ula_q[0].out, ula_q[0].zero);
        end
        @(posedge clock); #1;
        x = ula_q.pop_front();
        checks++;
        if (bus.flags !== x.flags) begin
            errors++; $display("FAIL ula_flags op=%0d a=%h b=%h got %b want %b", x.op, x.a, x.b, bus.flags, x.flags);
        end
    endtask

    task automatic test_ula_directed();
        ula_exp_t t[$];
        t.push_back('{32'd7, 32'd5, 5'd0, 32'd12, 1'b0, 4'b0000});
        t.push_back('{32'd7, 32'd5, 5'd1, 32'd2, 1'b0, 4'b0010});
        t.push_back('{32'd5, 32'd5, 5'd1, 32'd0, 1'b1, 4'b0110});
        t.push_back('{32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 4'b1001});
        t.push_back('{32'h8000_0000, 32'd4, 5'd8, 32'hF800_0000, 1'b0, 4'b1000});
        t.push_back('{32'h8000_0000, 32'd4, 5'd7, 32'h0800_0000, 1'b0, 4'b0000});
        t.push_back('{32'hFFFF_FFFF, 32'd0, 5'd9, 32'd1, 1'b0, 4'b0000});
        t.push_back('{32'hFFFF_FFFF, 32'd0, 5'd10, 32'd0, 1'b1, 4'b0100});
        t.push_back('{32'h8000_0000, 32'd4, 5'd20, 32'd0, 1'b1, 4'b0100});
        t.push_back('{32'hFFFF_FFFF, 32'd3, 5'd12, 32'd0, 1'b1, 4'b0110});
        t.push_back('{32'h8000_0000, 32'd3, 5'd13, 32'h7FFF_FFFF, 1'b0, 4'b0011});
        t.push_back('{32'd3, 32'd5, 5'd1, 32'hFFFF_FFFE, 1'b0, 4'b1000});
        t.push_back('{32'hF0F0_0000, 32'h0FF0_0000, 5'd15, 32'h000F_FFFF, 1'b0, 4'b0000});
        foreach (t[i]) drive_ula_item(t[i]);
    endtask

    task automatic test_ula_random();
        ula_exp_t it;
        logic [31:0] edges[4];
        edges[0] = 32'h0; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h7FFF_FFFF; edges[3] = 32'h8000_0000;
        for (int i = 0; i < 96; i++) begin
            it.a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            it.b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            it.op = (i < 64) ? 5'(i % 16) : 5'($urandom_range(0, 31));
            model_ula(it.a, it.b, it.op, it.out, it.flags);
            it.zero = (it.out == 32'd0);
            drive_ula_item(it);
        end
    endtask

    task automatic test_adder();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            d = (i == 0) ? 32'd0 : (i == 1) ? 32'hFFFF_FFFF : $urandom;
            bus.dataA = d;
            #1;
            checks++;
            if (bus.result !== ((i == 1) ? 32'd0 : d + 32'd1)) begin
                errors++; $display("FAIL adder dataA=%h got %h", d, bus.result);
            end
        end
    endtask

    task automatic test_bios_abort();
        logic [32:0] e;
        @(negedge clock);
        bus.A = 32'd5; bus.B = 32'd5; bus.opcode = 5'd1;
        reset = 1'b0;
        #1;
        checks++; if (bus.bios_done !== 1'b0 || bus.captured_data !== BASE) begin
            errors++; $display("FAIL abort_pre got %b/%h want 0/%h", bus.bios_done, bus.captured_data, BASE);
        end
        for (int i = 0; i <= 3; i++) bios_q.push_back({1'b0, BASE | 32'(i)});
        @(negedge clock) reset = 1'b1;
        #1;
        while (bios_q.size() > 0) begin
            e = bios_q.pop_front();
            checks++;
            if ({bus.bios_done, bus.captured_data} !== e) begin
                errors++; $display("FAIL abort_run got %b/%h want %b/%h", bus.bios_done, bus.captured_data, e[32], e[31:0]);
            end
            if (bios_q.size() > 0) begin @(posedge clock); #1; end
        end
        checks++; if (bus.flags !== 4'b0110) begin errors++; $display("FAIL abort_flags_live got %b want 0110", bus.flags); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.captured_data !== BASE || bus.bios_done !== 1'b0 || bus.flags !== 4'b0) begin
            errors++; $display("FAIL abort_async got %h/%b/%b want %h/0/0000", bus.captured_data, bus.bios_done, bus.flags, BASE);
        end
        for (int i = 0; i < DEPTH; i++) bios_q.push_back({1'b0, BASE | 32'(i)});
        for (int i = 0; i < 4; i++) bios_q.push_back({1'b1, 32'd0});
        @(negedge clock) reset = 1'b1;
        #1;
        while (bios_q.size() > 0) begin
            e = bios_q.pop_front();
            checks++;
            if ({bus.bios_done, bus.captured_data} !== e) begin
                errors++; $display("FAIL abort_restart got %b/%h want %b/%h", bus.bios_done, bus.captured_data, e[32], e[31:0]);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        test_reset();
        test_bios_sequence();
        test_ula_directed();
        test_ula_random();
        test_adder();
        test_bios_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
